// File: rtl/axi_pkg.sv
// Shared AXI4 types for the memory slave: burst kinds, response codes, FSM states.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    // Only these lengths form a legal WRAP; anything else degrades to INCR.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_mem_slave_if.sv
// AXI4 bus bundle between a master and the memory slave (five channels).
interface axi_mem_slave_if #(
    parameter int AW  = 32,
    parameter int DW  = 64,
    parameter int IDW = 4
);
    logic            arvalid;
    logic            arready;
    logic [AW-1:0]   araddr;
    logic [IDW-1:0]  arid;
    logic [1:0]      arburst;
    logic [7:0]      arlen;
    logic [2:0]      arsize;

    logic            rvalid;
    logic            rready;
    logic [DW-1:0]   rdata;
    logic [IDW-1:0]  rid;
    logic [1:0]      rresp;
    logic            rlast;

    logic            awvalid;
    logic            awready;
    logic [AW-1:0]   awaddr;
    logic [IDW-1:0]  awid;
    logic [1:0]      awburst;
    logic [7:0]      awlen;
    logic [2:0]      awsize;

    logic            wvalid;
    logic            wready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;

    logic            bvalid;
    logic            bready;
    logic [IDW-1:0]  bid;
    logic [1:0]      bresp;

    modport slave (
        input  arvalid, araddr, arid, arburst, arlen, arsize,
        output arready,
        output rvalid, rdata, rid, rresp, rlast,
        input  rready,
        input  awvalid, awaddr, awid, awburst, awlen, awsize,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready
    );

    modport master (
        output arvalid, araddr, arid, arburst, arlen, arsize,
        input  arready,
        input  rvalid, rdata, rid, rresp, rlast,
        output rready,
        output awvalid, awaddr, awid, awburst, awlen, awsize,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready
    );

endinterface

// File: rtl/axi_burst_addr.sv
// Combinational AXI4 next-beat address: FIXED, INCR, WRAP; reserved burst and
// illegal WRAP lengths advance as INCR, oversize beats are clamped to bus width.
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic [AW-1:0] addr_i,
    input  logic [2:0]    size_i,
    input  logic [7:0]    len_i,
    input  logic [1:0]    burst_i,
    output logic [AW-1:0] next_addr_o
);
    localparam int         OFFB     = $clog2(DW/8);
    localparam logic [2:0] MAX_SIZE = 3'(OFFB);

    logic [2:0]    eff_size;
    logic [AW-1:0] step;
    logic [AW-1:0] aligned;
    logic [AW-1:0] incr_addr;
    logic [AW-1:0] wrap_mask;

    always_comb begin
        eff_size    = (size_i > MAX_SIZE) ? MAX_SIZE : size_i;
        step        = AW'(1) << eff_size;
        aligned     = addr_i & ~(step - AW'(1));
        incr_addr   = aligned + step;
        wrap_mask   = ((AW'(len_i) + AW'(1)) << eff_size) - AW'(1);
        next_addr_o = incr_addr;
        if (burst_i == BURST_FIXED) begin
            next_addr_o = addr_i;
        end else if ((burst_i == BURST_WRAP) && wrap_len_ok(len_i)) begin
            next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
        end
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 burst memory slave with independent read/write FSMs over a byte-strobed word array.
// Build option AXI_MEM_ERR_RESP_EN: out-of-range addresses get SLVERR instead of aliasing.
module axi_mem_slave
    import axi_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 64,
    parameter int IDW   = 4,
    parameter int DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst,
    axi_mem_slave_if.slave    s_axi
);
    localparam int OFFB = $clog2(DW/8);
    localparam int IDXB = $clog2(DEPTH);
    localparam int IDXH = OFFB + IDXB;
`ifdef AXI_MEM_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    function automatic logic addr_oob(input logic [AW-1:0] a);
        return ERR_EN && ((a >> IDXH) != '0);
    endfunction

    logic [DW-1:0] mem [DEPTH];

    rd_state_e      rd_state_q;
    logic           arready_q, rvalid_q, rlast_q;
    logic [DW-1:0]  rdata_q;
    logic [1:0]     rresp_q;
    logic [IDW-1:0] rid_q;
    logic [AW-1:0]  raddr_q, raddr_d, rd_addr;
    logic [7:0]     rlen_q, rbeat_q, rd_beat;
    logic [2:0]     rsize_q;
    logic [1:0]     rburst_q;
    logic           rd_oob;

    wr_state_e      wr_state_q;
    logic           awready_q, wready_q, bvalid_q, werr_q;
    logic [1:0]     bresp_q;
    logic [IDW-1:0] wid_q;
    logic [AW-1:0]  waddr_q, waddr_d;
    logic [7:0]     wlen_q, wbeat_q;
    logic [2:0]     wsize_q;
    logic [1:0]     wburst_q;
    logic           w_hs, w_last_beat, w_oob, w_err_now;

    axi_burst_addr #(.AW(AW), .DW(DW)) u_rd_addr (
        .addr_i(raddr_q), .size_i(rsize_q), .len_i(rlen_q), .burst_i(rburst_q),
        .next_addr_o(raddr_d)
    );

    axi_burst_addr #(.AW(AW), .DW(DW)) u_wr_addr (
        .addr_i(waddr_q), .size_i(wsize_q), .len_i(wlen_q), .burst_i(wburst_q),
        .next_addr_o(waddr_d)
    );

    // The first fetch after AR uses the captured address; later fetches prefetch the next beat.
    always_comb begin
        rd_addr = rvalid_q ? raddr_d : raddr_q;
        rd_beat = rvalid_q ? (rbeat_q + 8'd1) : rbeat_q;
        rd_oob  = addr_oob(rd_addr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rid_q      <= '0;
            raddr_q    <= '0;
            rlen_q     <= '0;
            rbeat_q    <= '0;
            rsize_q    <= '0;
            rburst_q   <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (arready_q && s_axi.arvalid) begin
                        raddr_q    <= s_axi.araddr;
                        rid_q      <= s_axi.arid;
                        rlen_q     <= s_axi.arlen;
                        rsize_q    <= s_axi.arsize;
                        rburst_q   <= s_axi.arburst;
                        rbeat_q    <= '0;
                        arready_q  <= 1'b0;
                        rd_state_q <= R_DATA;
                    end else begin
                        arready_q  <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (!rvalid_q || s_axi.rready) begin
                        if (rvalid_q && rlast_q) begin
                            rvalid_q   <= 1'b0;
                            rlast_q    <= 1'b0;
                            rd_state_q <= R_IDLE;
                        end else begin
                            rvalid_q <= 1'b1;
                            raddr_q  <= rd_addr;
                            rbeat_q  <= rd_beat;
                            rlast_q  <= (rd_beat == rlen_q);
                            rdata_q  <= rd_oob ? '0 : mem[rd_addr[OFFB +: IDXB]];
                            rresp_q  <= ((rburst_q == BURST_RSVD) || rd_oob) ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    // Burst length comes from the beat counter; wlast only feeds the error flag.
    always_comb begin
        w_hs        = (wr_state_q == W_DATA) && wready_q && s_axi.wvalid;
        w_last_beat = (wbeat_q == wlen_q);
        w_oob       = addr_oob(waddr_q);
        w_err_now   = werr_q || (s_axi.wlast != w_last_beat) || w_oob;
    end

    always_ff @(posedge clk) begin
        if (w_hs && !rst && !w_oob) begin
            for (int b = 0; b < DW/8; b++) begin
                if (s_axi.wstrb[b]) begin
                    mem[waddr_q[OFFB +: IDXB]][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            werr_q     <= 1'b0;
            wid_q      <= '0;
            waddr_q    <= '0;
            wlen_q     <= '0;
            wbeat_q    <= '0;
            wsize_q    <= '0;
            wburst_q   <= '0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (awready_q && s_axi.awvalid) begin
                        waddr_q    <= s_axi.awaddr;
                        wid_q      <= s_axi.awid;
                        wlen_q     <= s_axi.awlen;
                        wsize_q    <= s_axi.awsize;
                        wburst_q   <= s_axi.awburst;
                        wbeat_q    <= '0;
                        werr_q     <= (s_axi.awburst == BURST_RSVD);
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                        wr_state_q <= W_DATA;
                    end else begin
                        awready_q  <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if (w_last_beat) begin
                            wready_q   <= 1'b0;
                            bvalid_q   <= 1'b1;
                            bresp_q    <= w_err_now ? RESP_SLVERR : RESP_OKAY;
                            wr_state_q <= W_RESP;
                        end else begin
                            waddr_q    <= waddr_d;
                            wbeat_q    <= wbeat_q + 8'd1;
                            werr_q     <= w_err_now;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        bvalid_q   <= 1'b0;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rid     = rid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bid     = wid_q;
    assign s_axi.bresp   = bresp_q;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave (DW=64): bursts, strobes, backpressure, errors, reset.
module tb_axi_mem_slave;

    typedef logic [63:0] words_t [16];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    axi_mem_slave_if #(.AW(32), .DW(64), .IDW(4)) bus ();

    axi_mem_slave #(.AW(32), .DW(64), .IDW(4), .DEPTH(1024)) dut (
        .clk   (clk),
        .rst   (rst),
        .s_axi (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [1:0] burst,
                            input int len, input words_t data, input logic [7:0] strb, input int wlast_at,
                            output logic [1:0] resp, output logic [3:0] bid, output int w_lat, output int b_lat);
        int n;
        w_lat = -1;
        bus.awaddr = addr; bus.awid = id; bus.awburst = burst;
        bus.awlen = 8'(len); bus.awsize = 3'd3; bus.awvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < 50) begin tick; n++; end
        if (!bus.awready) check("awready_timeout", 64'(bus.awready), 64'd1);
        tick;
        bus.awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            bus.wdata = data[i]; bus.wstrb = strb; bus.wlast = (i == wlast_at); bus.wvalid = 1'b1;
            n = 0;
            while (!bus.wready && n < 50) begin tick; n++; end
            if (i == 0) w_lat = n;
            if (!bus.wready) check("wready_timeout", 64'(bus.wready), 64'd1);
            tick;
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        n = 0;
        while (!bus.bvalid && n < 50) begin tick; n++; end
        b_lat = n;
        if (!bus.bvalid) check("bvalid_timeout", 64'(bus.bvalid), 64'd1);
        resp = bus.bresp; bid = bus.bid;
        bus.bready = 1'b1;
        tick;
        bus.bready = 1'b0;
        $display("write addr=%h burst=%0d len=%0d id=%0d bresp=%0d bid=%0d", addr, burst, len, id, resp, bid);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [1:0] burst,
                           input int len, input bit toggle, output words_t data, output logic [15:0] lasts,
                           output logic [1:0] resp, output logic [3:0] rid, output int r_lat);
        int n, beat, cyc;
        logic [63:0] held_data;
        logic        held_last;
        data = '{default: '0}; lasts = '0; resp = 2'b00; rid = '0; r_lat = -1;
        bus.araddr = addr; bus.arid = id; bus.arburst = burst;
        bus.arlen = 8'(len); bus.arsize = 3'd3; bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < 50) begin tick; n++; end
        if (!bus.arready) check("arready_timeout", 64'(bus.arready), 64'd1);
        tick;
        bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        beat = 0; cyc = 0;
        while (beat <= len && cyc < 200) begin
            if (bus.rvalid && r_lat < 0) r_lat = cyc;
            if (bus.rvalid && bus.rready) begin
                data[beat] = bus.rdata; lasts[beat] = bus.rlast;
                resp = resp | bus.rresp; rid = bus.rid;
                beat++;
                tick;
            end else if (bus.rvalid) begin
                held_data = bus.rdata; held_last = bus.rlast;
                tick;
                check("stall_rdata", bus.rdata, held_data);
                check("stall_rlast", 64'(bus.rlast), 64'(held_last));
            end else begin
                tick;
            end
            cyc++;
            if (toggle) bus.rready = ~bus.rready;
        end
        if (beat <= len) check("read_beats", 64'(beat), 64'(len + 1));
        bus.rready = 1'b1;
        $display("read addr=%h burst=%0d len=%0d id=%0d rresp=%0d first=%h", addr, burst, len, id, resp, data[0]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        words_t      d, q;
        logic [15:0] lasts;
        logic [1:0]  resp;
        logic [3:0]  id_o;
        int          wl, bl, rl;

        bus.arvalid = 0; bus.araddr = '0; bus.arid = '0; bus.arburst = '0; bus.arlen = '0; bus.arsize = '0;
        bus.rready = 1; bus.awvalid = 0; bus.awaddr = '0; bus.awid = '0; bus.awburst = '0;
        bus.awlen = '0; bus.awsize = '0; bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 0;
        bus.bready = 0;

        rst = 1'b1;
        repeat (3) tick;
        check("rst_arready", 64'(bus.arready), 64'd0);
        check("rst_awready", 64'(bus.awready), 64'd0);
        check("rst_rvalid",  64'(bus.rvalid),  64'd0);
        check("rst_wready",  64'(bus.wready),  64'd0);
        check("rst_bvalid",  64'(bus.bvalid),  64'd0);
        rst = 1'b0;
        tick;
        check("post_rst_arready", 64'(bus.arready), 64'd1);
        check("post_rst_awready", 64'(bus.awready), 64'd1);

        // INCR round trip
        d = '{default: '0};
        d[0] = 64'h1111_1111_1111_1111; d[1] = 64'h2222_2222_2222_2222;
        d[2] = 64'h3333_3333_3333_3333; d[3] = 64'h4444_4444_4444_4444;
        do_write(32'h100, 4'd5, 2'b01, 3, d, 8'hFF, 3, resp, id_o, wl, bl);
        check("incr_bresp", 64'(resp), 64'd0);
        check("incr_bid", 64'(id_o), 64'd5);
        check("wready_latency", 64'(wl), 64'd0);
        check("bvalid_latency", 64'(bl), 64'd0);
        do_read(32'h100, 4'd9, 2'b01, 3, 1'b0, q, lasts, resp, id_o, rl);
        for (int i = 0; i < 4; i++) check($sformatf("incr_rdata%0d", i), q[i], d[i]);
        check("incr_rlast", 64'(lasts), 64'h0008);
        check("incr_rid", 64'(id_o), 64'd9);
        check("incr_rresp", 64'(resp), 64'd0);
        check("rvalid_latency", 64'(rl), 64'd1);

        // WRAP read starting mid-window
        do_read(32'h118, 4'd3, 2'b10, 3, 1'b0, q, lasts, resp, id_o, rl);
        check("wrap_b0", q[0], 64'h4444_4444_4444_4444);
        check("wrap_b1", q[1], 64'h1111_1111_1111_1111);
        check("wrap_b2", q[2], 64'h2222_2222_2222_2222);
        check("wrap_b3", q[3], 64'h3333_3333_3333_3333);

        // FIXED write keeps only the last beat
        d = '{default: '0};
        d[0] = 64'hAAAA_AAAA_AAAA_AAAA; d[1] = 64'hBBBB_BBBB_BBBB_BBBB; d[2] = 64'hCCCC_CCCC_CCCC_CCCC;
        do_write(32'h200, 4'd1, 2'b00, 2, d, 8'hFF, 2, resp, id_o, wl, bl);
        check("fixed_bresp", 64'(resp), 64'd0);
        do_read(32'h200, 4'd1, 2'b01, 0, 1'b0, q, lasts, resp, id_o, rl);
        check("fixed_rdata", q[0], 64'hCCCC_CCCC_CCCC_CCCC);
        check("single_rlast", 64'(lasts), 64'h0001);

        // Byte strobes
        d = '{default: '0};
        d[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        do_write(32'h300, 4'd2, 2'b01, 0, d, 8'hFF, 0, resp, id_o, wl, bl);
        d[0] = 64'h0;
        do_write(32'h300, 4'd2, 2'b01, 0, d, 8'h0F, 0, resp, id_o, wl, bl);
        do_read(32'h300, 4'd2, 2'b01, 0, 1'b0, q, lasts, resp, id_o, rl);
        check("strobe_rdata", q[0], 64'hFFFF_FFFF_0000_0000);

        // Read backpressure over an 8-beat burst
        d = '{default: '0};
        for (int i = 0; i < 8; i++) d[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
        do_write(32'h400, 4'd4, 2'b01, 7, d, 8'hFF, 7, resp, id_o, wl, bl);
        do_read(32'h400, 4'd6, 2'b01, 7, 1'b1, q, lasts, resp, id_o, rl);
        for (int i = 0; i < 8; i++) check($sformatf("bp_rdata%0d", i), q[i], d[i]);
        check("bp_rlast", 64'(lasts), 64'h0080);

        // Early wlast, then a clean write to confirm the error flag is per burst
        d = '{default: '0};
        do_write(32'h500, 4'd7, 2'b01, 3, d, 8'hFF, 1, resp, id_o, wl, bl);
        check("early_wlast_bresp", 64'(resp), 64'd2);
        do_write(32'h508, 4'd7, 2'b01, 0, d, 8'hFF, 0, resp, id_o, wl, bl);
        check("clean_bresp", 64'(resp), 64'd0);
        do_read(32'h100, 4'd8, 2'b11, 1, 1'b0, q, lasts, resp, id_o, rl);
        check("rsvd_rresp", 64'(resp), 64'd2);
        check("rsvd_b1", q[1], 64'h2222_2222_2222_2222);

        // Reset during beat 2 of a write
        bus.awaddr = 32'h600; bus.awid = 4'd2; bus.awburst = 2'b01; bus.awlen = 8'd3;
        bus.awsize = 3'd3; bus.awvalid = 1'b1;
        wl = 0;
        while (!bus.awready && wl < 50) begin tick; wl++; end
        tick;
        bus.awvalid = 1'b0;
        bus.wdata = 64'h6666_6666_6666_6666; bus.wstrb = 8'hFF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
        wl = 0;
        while (!bus.wready && wl < 50) begin tick; wl++; end
        tick;
        bus.wdata = 64'h7777_7777_7777_7777;
        rst = 1'b1;
        tick;
        $display("reset pulse during write burst at 0x600");
        check("midrst_awready", 64'(bus.awready), 64'd0);
        check("midrst_arready", 64'(bus.arready), 64'd0);
        check("midrst_wready",  64'(bus.wready),  64'd0);
        check("midrst_bvalid",  64'(bus.bvalid),  64'd0);
        check("midrst_rvalid",  64'(bus.rvalid),  64'd0);
        check("midrst_rdata",   bus.rdata,        64'd0);
        check("midrst_bid",     64'(bus.bid),     64'd0);
        rst = 1'b0; bus.wvalid = 1'b0;
        tick;
        check("release_awready", 64'(bus.awready), 64'd1);
        check("release_arready", 64'(bus.arready), 64'd1);
        do_read(32'h600, 4'd1, 2'b01, 0, 1'b0, q, lasts, resp, id_o, rl);
        check("midrst_kept_word", q[0], 64'h6666_6666_6666_6666);

        // Upper address bits: alias or SLVERR depending on build
        d = '{default: '0};
        d[0] = 64'h0123_4567_89AB_CDEF;
        do_write(32'h0, 4'd3, 2'b01, 0, d, 8'hFF, 0, resp, id_o, wl, bl);
        d[0] = 64'hDEAD_BEEF_DEAD_BEEF;
        do_write(32'h4000, 4'd3, 2'b01, 0, d, 8'hFF, 0, resp, id_o, wl, bl);
`ifdef AXI_MEM_ERR_RESP_EN
        check("oob_bresp", 64'(resp), 64'd2);
        do_read(32'h0, 4'd3, 2'b01, 0, 1'b0, q, lasts, resp, id_o, rl);
        check("oob_word0_kept", q[0], 64'h0123_4567_89AB_CDEF);
        do_read(32'h4000, 4'd3, 2'b01, 0, 1'b0, q, lasts, resp, id_o, rl);
        check("oob_rdata", q[0], 64'd0);
        check("oob_rresp", 64'(resp), 64'd2);
`else
        check("alias_bresp", 64'(resp), 64'd0);
        do_read(32'h0, 4'd3, 2'b01, 0, 1'b0, q, lasts, resp, id_o, rl);
        check("alias_word0", q[0], 64'hDEAD_BEEF_DEAD_BEEF);
        check("alias_rresp", 64'(resp), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
